instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of instr_mem. Owns the PC, drives the instr_mem strobe/ack
//  port and buffers {pc, instr} pairs in a small FIFO feeding decode over a valid/ready handshake.
//  Handles control-flow redirects from execute, including discarding a response already in flight.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset
//  FIFO_DEPTH  2              instruction buffer entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  o_imem_addr     out  32  byte address to instr_mem
//  o_imem_stb      out  1   request strobe; held with stable addr until ack
//  i_imem_ack      in   1   request complete; i_imem_data valid this cycle
//  i_imem_data     in   32  instruction word
//  o_valid         out  1   FIFO head valid toward decode
//  o_instr         out  32  FIFO head instruction
//  o_pc            out  32  FIFO head PC
//  i_ready         in   1   decode accepts head when o_valid & i_ready
//  i_redirect      in   1   flush and restart fetch at i_redirect_pc
//  i_redirect_pc   in   32  redirect target
//  o_misaligned    out  1   head entry is a misaligned-fetch marker (FETCH_MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, state=REQ; o_imem_stb=0, o_imem_addr=RESET_PC, o_valid=0, o_instr=0,
//    o_pc=0, o_misaligned=0. Reset mid-request drops it; a late ack after reset is ignored.
//  - One outstanding request max. Issue (stb=1) only when FIFO occupancy < FIFO_DEPTH, counted at issue.
//    Once raised, stb and addr are held until ack regardless of i_ready.
//  - First cycle after rst deasserts: stb=1, addr=RESET_PC.
//  - Ack in cycle N: {pc, i_imem_data} pushed, visible at FIFO head in N+1 (if FIFO was empty);
//    pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); stb may stay high in N+1 with the new addr -> 1 instr/cycle.
//  - FIFO full: stb stays 0 until a pop frees a slot. Push and pop in the same cycle keep occupancy.
//  - States: REQ (normal fetch), DRAIN (discard one stale ack), HALT (misaligned, macro only).
//  - i_redirect (priority over everything, any state): FIFO flushed, o_valid=0 next cycle,
//    pc<=i_redirect_pc. If a request is outstanding and ack not in this cycle -> DRAIN: stb held with the
//    old addr until ack, data dropped, then REQ at the new pc. Ack in the redirect cycle: data dropped, go to REQ.
//    Redirect while in DRAIN: update target pc, remain in DRAIN.
//  - Pop in the redirect cycle is still a legal handshake to decode; the flush applies to remaining entries.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: a redirect target with pc[1:0]!=0 issues no memory request; one entry
//    {pc, 32'h0000_0013} with o_misaligned=1 is pushed, then state=HALT (stb=0) until the next redirect.
//  Undefined: i_redirect_pc[1:0] forced to 2'b00 on capture; no HALT state; o_misaligned tied 0.
// STRUCTURE
//  Header fetch_defs.vh: state encodings (S_REQ, S_DRAIN, S_HALT), NOP_INSTR=32'h0000_0013, PC_STEP=4.
//  Sub-module fetch_fifo: synchronous FIFO (WIDTH, DEPTH), flush input, full/empty/count outputs;
//  entry {misaligned, pc, instr} = 65 bits.
//  The top level holds the PC, FSM and issue-credit logic.
// TESTING
//  1. Reset, memory acks 1 cycle after stb, i_ready=1 -> addrs 0,4,8 issued; o_pc 0,4,8 appear with
//     o_valid one cycle after each ack.
//  2. i_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered; stb=0 while full; first pop re-raises stb, addr=8.
//  3. Redirect to 0x100 while a request is pending with ack 3 cycles later -> DRAIN; stale data never reaches
//     o_valid; next addr=0x100.
//  4. Redirect to 0x40 in the same cycle as ack -> ack data discarded; next stb addr=0x40; FIFO empty.
//  5. Redirect to 0x09: macro on -> no stb, o_valid=1, o_pc=0x09, o_misaligned=1, instr=0x13, then idle;
//     macro off -> addr=0x08 fetched.
//  6. Run to pc=32'hFFFF_FFFC -> next addr 0; rst asserted mid-request -> stb=0 next cycle, late ack ignored.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional misaligned-fetch trap is enabled with `define FETCH_MISALIGN_TRAP_EN.
package instr_fetch_pkg;

    // Fetch controller states: normal fetch, discard one stale ack, halted on misaligned target
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    // Instruction injected with a misaligned-fetch marker (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch increment in bytes
    localparam logic [31:0] PC_STEP = 32'd4;

    // One buffered fetch result as seen by decode
    typedef struct packed {
        logic        misaligned;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instr_fetch_fifo.sv
// Show-ahead synchronous FIFO holding fetched {misaligned, pc, instr} entries.
// Head reads as zero while empty so decode never sees stale data. Flush empties it in one cycle.
module instr_fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign count     = count_reg;
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the single-outstanding instr_mem request and buffers
// results for decode. Redirects flush the buffer; a request already in flight is drained
// and its data dropped.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target produces a
// marker entry and halts fetch until the next redirect; otherwise target bits [1:0] are cleared).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stb,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misaligned
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  addr_reg, addr_next;
    logic         stb_reg, stb_next;

    logic         ack_ok;
    logic         outstanding_next;
    logic         misaligned_next;
    logic [31:0]  redirect_target;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // An ack only counts while our strobe is up; anything else is a leftover from before reset
    assign ack_ok   = stb_reg & i_imem_ack;
    assign fifo_pop = o_valid & i_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = i_redirect_pc;
    assign misaligned_next = (pc_next[1:0] != 2'b00);
`else
    assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;
    assign misaligned_next = 1'b0;
`endif

    // Next-state, PC, buffer-push and issue-credit decisions
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        addr_next        = addr_reg;
        stb_next         = 1'b0;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        push_entry       = '{misaligned: 1'b0, pc: addr_reg, instr: i_imem_data};
        outstanding_next = stb_reg & ~i_imem_ack;

        if (i_redirect) begin
            fifo_flush = 1'b1;
            pc_next    = redirect_target;
            state_next = outstanding_next ? S_DRAIN : S_REQ;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (ack_ok && !fifo_full) begin
                        fifo_push = 1'b1;
                        pc_next   = pc_reg + PC_STEP;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    else if (!stb_reg && (pc_reg[1:0] != 2'b00) && !fifo_full) begin
                        fifo_push  = 1'b1;
                        push_entry = '{misaligned: 1'b1, pc: pc_reg, instr: NOP_INSTR};
                        state_next = S_HALT;
                    end
`endif
                end
                S_DRAIN: begin
                    if (ack_ok) begin
                        state_next = S_REQ;
                    end
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end

        // Occupancy as it will be next cycle, used to decide whether a new request fits
        if (fifo_flush) begin
            count_next = '0;
        end else begin
            count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end

        // A pending request keeps strobe and address frozen; otherwise issue if a slot is free
        if (outstanding_next) begin
            stb_next  = 1'b1;
            addr_next = addr_reg;
        end else begin
            stb_next  = (state_next == S_REQ) && !misaligned_next &&
                        (count_next < CNT_W'(FIFO_DEPTH));
            addr_next = pc_next;
        end
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            stb_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            stb_reg   <= stb_next;
        end
    end

    instr_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_imem_addr  = addr_reg;
    assign o_imem_stb   = stb_reg;
    assign o_valid      = ~fifo_empty;
    assign o_pc         = head_entry.pc;
    assign o_instr      = head_entry.instr;
    assign o_misaligned = head_entry.misaligned;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven startup vectors, directed redirect /
// wrap / reset sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] o_imem_addr;
    logic        o_imem_stb;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misaligned;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_addr   (o_imem_addr),
        .o_imem_stb    (o_imem_stb),
        .i_imem_ack    (i_imem_ack),
        .i_imem_data   (i_imem_data),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_ready       (i_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_misaligned  (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a simple hash of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit m_mis(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          mis;
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req;
    bit          m_busy;
    bit          m_stale;
    bit          m_halt;

    function automatic ent_t mk(input bit mis, input logic [31:0] pc, input logic [31:0] instr);
        ent_t e;
        e.mis = mis; e.pc = pc; e.instr = instr;
        return e;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pc = RPC; m_req = RPC; m_busy = 0; m_stale = 0; m_halt = 0;
    endfunction

    // One clock of the fetch rules: pop, redirect/flush, ack handling, marker, then issue
    function automatic void model_step(input bit r, input bit rdy, input bit ack,
                                       input logic [31:0] data, input bit redir,
                                       input logic [31:0] rpc);
        bit          was_busy;
        bit          was_halt;
        int          was_n;
        logic [31:0] was_pc;
        if (r) begin
            model_reset();
            return;
        end
        was_busy = m_busy; was_halt = m_halt; was_n = mq.size(); was_pc = m_pc;
        if (redir) begin
            mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = rpc;
`else
            m_pc = rpc & 32'hFFFF_FFFC;
`endif
            m_stale = m_busy && !ack;
            m_busy  = m_stale;
            m_halt  = 0;
        end else begin
            if (was_n > 0 && rdy) void'(mq.pop_front());
            if (m_busy && ack) begin
                if (m_stale) m_stale = 0;
                else begin
                    mq.push_back(mk(0, m_req, data));
                    m_pc = m_pc + 32'd4;
                end
                m_busy = 0;
            end else if (!was_busy && !was_halt && m_mis(was_pc) && was_n < DEPTH) begin
                mq.push_back(mk(1, was_pc, 32'h0000_0013));
                m_halt = 1;
            end
        end
        if (!m_busy && !m_halt && !m_mis(m_pc) && mq.size() < DEPTH) begin
            m_busy = 1;
            m_req  = m_pc;
        end
    endfunction

    // ---------------- cycle driver ----------------
    bit auto_mem = 0;
    bit rand_lat = 0;
    int lat      = 1;
    int wait_cnt = 0;
    bit s_stb;

    // First half of a cycle: memory responder, then compare DUT against the model
    task automatic to_neg();
        if (auto_mem) i_imem_ack = o_imem_stb && (wait_cnt >= lat);
        i_imem_data = mem_word(o_imem_addr);
        @(negedge clk);
        s_stb = o_imem_stb;
        check("stb", {31'd0, o_imem_stb}, {31'd0, m_busy});
        if (m_busy) check("addr", o_imem_addr, m_req);
        check("valid", {31'd0, o_valid}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            check("head_pc", o_pc, mq[0].pc);
            check("head_instr", o_instr, mq[0].instr);
            check("head_mis", {31'd0, o_misaligned}, {31'd0, mq[0].mis});
        end
    endtask

    // Second half: clock edge, model update, responder bookkeeping
    task automatic to_next();
        @(posedge clk);
        model_step(rst, i_ready, i_imem_ack, i_imem_data, i_redirect, i_redirect_pc);
        if (rst) wait_cnt = 0;
        else if (auto_mem) begin
            if (i_imem_ack) begin
                wait_cnt = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else if (s_stb) wait_cnt++;
        end
        $display("cyc t=%0t rst=%0b stb=%0b addr=%h ack=%0b redir=%0b valid=%0b pc=%h rdy=%0b",
                 $time, rst, s_stb, o_imem_addr, i_imem_ack, i_redirect, o_valid, o_pc, i_ready);
        #1;
    endtask

    task automatic step();
        to_neg();
        to_next();
    endtask

    task automatic do_reset();
        rst = 1; i_redirect = 0; i_imem_ack = 0;
        step();
        rst = 0;
    endtask

    // Startup vectors: ack one cycle after each strobe, decode always ready
    typedef struct {
        bit          ready;
        bit          ack;
        bit          e_stb;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tv[8];

    initial begin
        tv[0] = '{1, 0, 0, 32'h0, 0, 32'h0};
        tv[1] = '{1, 0, 1, 32'h0, 0, 32'h0};
        tv[2] = '{1, 1, 1, 32'h0, 0, 32'h0};
        tv[3] = '{1, 0, 1, 32'h4, 1, 32'h0};
        tv[4] = '{1, 1, 1, 32'h4, 0, 32'h0};
        tv[5] = '{1, 0, 1, 32'h8, 1, 32'h4};
        tv[6] = '{1, 1, 1, 32'h8, 0, 32'h0};
        tv[7] = '{1, 0, 1, 32'hC, 1, 32'h8};

        rst = 1; i_imem_ack = 0; i_imem_data = 0; i_ready = 0;
        i_redirect = 0; i_redirect_pc = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 0;

        // ---- 1: startup fetch stream ----
        for (int i = 0; i < 8; i++) begin
            i_ready = tv[i].ready;
            i_imem_ack = tv[i].ack;
            to_neg();
            if (i == 0) begin
                check("rst_addr", o_imem_addr, RPC);
                check("rst_instr", o_instr, 32'h0);
                check("rst_pc", o_pc, 32'h0);
                check("rst_mis", {31'd0, o_misaligned}, 32'h0);
            end
            check("tv_stb", {31'd0, o_imem_stb}, {31'd0, tv[i].e_stb});
            if (tv[i].e_stb) check("tv_addr", o_imem_addr, tv[i].e_addr);
            check("tv_valid", {31'd0, o_valid}, {31'd0, tv[i].e_valid});
            if (tv[i].e_valid) begin
                check("tv_pc", o_pc, tv[i].e_pc);
                check("tv_instr", o_instr, mem_word(tv[i].e_pc));
            end
            to_next();
        end

        // ---- 2: back-pressure fills the buffer ----
        i_ready = 0; i_imem_ack = 0;
        do_reset();
        auto_mem = 1; rand_lat = 0; lat = 1; wait_cnt = 0;
        for (int i = 0; i < 10; i++) step();
        to_neg();
        check("full_stb", {31'd0, o_imem_stb}, 32'h0);
        check("full_valid", {31'd0, o_valid}, 32'h1);
        check("full_pc", o_pc, 32'h0);
        i_ready = 1;
        to_next();
        i_ready = 0;
        to_neg();
        check("refill_stb", {31'd0, o_imem_stb}, 32'h1);
        check("refill_addr", o_imem_addr, 32'h8);
        check("refill_pc", o_pc, 32'h4);
        to_next();

        // ---- 3/4/5: redirects with manual memory timing ----
        auto_mem = 0; i_ready = 1;
        do_reset();
        step();                                              // cycle 0
        i_redirect = 1; i_redirect_pc = 32'h100; step();     // cycle 1: request pending
        i_redirect = 0;
        for (int i = 2; i <= 4; i++) begin
            i_imem_ack = (i == 4);
            to_neg();
            check("drain_stb", {31'd0, o_imem_stb}, 32'h1);
            check("drain_addr", o_imem_addr, 32'h0);
            check("drain_valid", {31'd0, o_valid}, 32'h0);
            to_next();
        end
        i_imem_ack = 1; i_redirect = 1; i_redirect_pc = 32'h40;
        to_neg();                                            // cycle 5
        check("post_drain_addr", o_imem_addr, 32'h100);
        check("post_drain_valid", {31'd0, o_valid}, 32'h0);
        to_next();
        i_imem_ack = 0; i_redirect = 0;
        to_neg();                                            // cycle 6
        check("redir_ack_addr", o_imem_addr, 32'h40);
        check("redir_ack_valid", {31'd0, o_valid}, 32'h0);
        to_next();
        i_imem_ack = 1; i_redirect = 1; i_redirect_pc = 32'h09; i_ready = 0;
        step();                                              // cycle 7
        i_imem_ack = 0; i_redirect = 0;
        to_neg();                                            // cycle 8
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_nostb", {31'd0, o_imem_stb}, 32'h0);
        to_next();
        to_neg();                                            // cycle 9
        check("mis_valid", {31'd0, o_valid}, 32'h1);
        check("mis_pc", o_pc, 32'h09);
        check("mis_flag", {31'd0, o_misaligned}, 32'h1);
        check("mis_instr", o_instr, 32'h13);
        to_next();
        i_ready = 1;
        for (int i = 0; i < 4; i++) begin
            to_neg();
            check("halt_stb", {31'd0, o_imem_stb}, 32'h0);
            to_next();
        end
`else
        check("mask_stb", {31'd0, o_imem_stb}, 32'h1);
        check("mask_addr", o_imem_addr, 32'h08);
        to_next();
        i_ready = 1;
`endif

        // ---- 6: PC wrap, then reset mid-request ----
        auto_mem = 1; rand_lat = 1; lat = 0; wait_cnt = 0;
        i_redirect = 1; i_redirect_pc = 32'hFFFF_FFF8; step();
        i_redirect = 0;
        begin
            bit seen_top = 0;
            bit done = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                to_neg();
                if (o_imem_stb && o_imem_addr == 32'hFFFF_FFFC) seen_top = 1;
                else if (seen_top && o_imem_stb) begin
                    check("wrap_addr", o_imem_addr, 32'h0);
                    done = 1;
                end
                to_next();
            end
            if (!done) check("wrap_timeout", 32'h0, 32'h1);
        end
        auto_mem = 0; i_imem_ack = 0;
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                to_neg();
                got = o_imem_stb;
                to_next();
            end
            if (!got) check("stb_timeout", 32'h0, 32'h1);
        end
        rst = 1; i_imem_ack = 0; step();
        rst = 0; i_imem_ack = 1;
        to_neg();
        check("rst_mid_stb", {31'd0, o_imem_stb}, 32'h0);
        to_next();
        i_imem_ack = 0;
        to_neg();
        check("rst_restart_stb", {31'd0, o_imem_stb}, 32'h1);
        check("rst_restart_addr", o_imem_addr, RPC);
        check("late_ack_valid", {31'd0, o_valid}, 32'h0);
        to_next();
        step();

        // ---- randomized traffic ----
        auto_mem = 1; rand_lat = 1; wait_cnt = 0; lat = 1;
        for (int i = 0; i < 3000; i++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            i_redirect = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: i_redirect_pc = $urandom & 32'h0000_0FFC;
                1: i_redirect_pc = $urandom & 32'h0000_0FFF;
                2: i_redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                default: i_redirect_pc = $urandom;
            endcase
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
